// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions for the operand-issue / writeback stage.
package alu_issue_pkg;

  // Operation codes understood by the core's combinational alu.
  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_AND = 3'd2,
    ALU_OP_OR  = 3'd3,
    ALU_OP_XOR = 3'd4,
    ALU_OP_SLL = 3'd5,
    ALU_OP_SRL = 3'd6,
    ALU_OP_SRA = 3'd7
  } alu_op_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two async read ports, a debug read port,
// one synchronous write port, synchronous reset to zero.
module alu_issue_regfile #(
  parameter int unsigned WORD_LEN = 64,
  parameter int unsigned NREGS    = 16,
  localparam int unsigned REG_BITS = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [REG_BITS-1:0] waddr_i,
  input  logic [WORD_LEN-1:0] wdata_i,
  input  logic [REG_BITS-1:0] raddr1_i,
  output logic [WORD_LEN-1:0] rdata1_o,
  input  logic [REG_BITS-1:0] raddr2_i,
  output logic [WORD_LEN-1:0] rdata2_o,
  input  logic [REG_BITS-1:0] dbg_addr_i,
  output logic [WORD_LEN-1:0] dbg_data_o
);

  logic [WORD_LEN-1:0] mem_q [NREGS];

  // Clear all entries on reset, otherwise perform the single write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = mem_q[raddr1_i];
  assign rdata2_o   = mem_q[raddr2_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue, EX and WB registers around an external combinational alu.
// Results in EX and WB are forwarded so dependent ops issue back-to-back.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WORD_LEN = 64,
  parameter int unsigned NREGS    = 16,
  localparam int unsigned REG_BITS = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  alu_op_t             in_opc_i,
  input  logic [REG_BITS-1:0] in_rd_i,
  input  logic [REG_BITS-1:0] in_rs1_i,
  input  logic [REG_BITS-1:0] in_rs2_i,
  input  logic [WORD_LEN-1:0] in_imm_i,
  input  logic                in_use_imm_i,
  input  logic                stall_i,
  output logic [WORD_LEN-1:0] alu_a_o,
  output logic [WORD_LEN-1:0] alu_b_o,
  output alu_op_t             alu_opc_o,
  input  logic [WORD_LEN-1:0] alu_res_i,
  output logic                wb_valid_o,
  output logic [REG_BITS-1:0] wb_rd_o,
  output logic [WORD_LEN-1:0] wb_data_o,
  input  logic [REG_BITS-1:0] dbg_addr_i,
  output logic [WORD_LEN-1:0] dbg_data_o
);

  typedef struct packed {
    logic                valid;
    alu_op_t             opc;
    logic [REG_BITS-1:0] rd;
    logic [WORD_LEN-1:0] a;
    logic [WORD_LEN-1:0] b;
  } ex_slot_t;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic [WORD_LEN-1:0] data;
  } wb_slot_t;

  ex_slot_t ex_q, ex_d;
  wb_slot_t wb_q, wb_d;

  logic                fire;
  logic                rf_we;
  logic [WORD_LEN-1:0] rf_rs1_data, rf_rs2_data;
  logic [WORD_LEN-1:0] rs1_val, rs2_val;

  assign in_ready_o = !stall_i;
  assign fire       = in_valid_i && in_ready_o;
  // The WB slot is held under stall, so gating with !stall_i commits it once.
  assign rf_we      = wb_q.valid && !stall_i && (wb_q.rd != '0);

  alu_issue_regfile #(
    .WORD_LEN(WORD_LEN),
    .NREGS   (NREGS)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (rf_we),
    .waddr_i   (wb_q.rd),
    .wdata_i   (wb_q.data),
    .raddr1_i  (in_rs1_i),
    .rdata1_o  (rf_rs1_data),
    .raddr2_i  (in_rs2_i),
    .rdata2_o  (rf_rs2_data),
    .dbg_addr_i(dbg_addr_i),
    .dbg_data_o(dbg_data_o)
  );

  // Operand select: r0, then youngest in-flight result (EX), then WB, then file.
  always_comb begin
    rs1_val = rf_rs1_data;
    if (in_rs1_i == '0) begin
      rs1_val = '0;
    end else if (ex_q.valid && (ex_q.rd == in_rs1_i)) begin
      rs1_val = alu_res_i;
    end else if (wb_q.valid && (wb_q.rd == in_rs1_i)) begin
      rs1_val = wb_q.data;
    end

    rs2_val = rf_rs2_data;
    if (in_rs2_i == '0) begin
      rs2_val = '0;
    end else if (ex_q.valid && (ex_q.rd == in_rs2_i)) begin
      rs2_val = alu_res_i;
    end else if (wb_q.valid && (wb_q.rd == in_rs2_i)) begin
      rs2_val = wb_q.data;
    end
  end

  // Next state for EX and WB; both hold while stalled.
  always_comb begin
    ex_d = ex_q;
    wb_d = wb_q;
    if (!stall_i) begin
      ex_d.valid = fire;
      if (fire) begin
        ex_d.opc = in_opc_i;
        ex_d.rd  = in_rd_i;
        ex_d.a   = rs1_val;
        ex_d.b   = in_use_imm_i ? in_imm_i : rs2_val;
      end
      wb_d.valid = ex_q.valid;
      wb_d.rd    = ex_q.rd;
      wb_d.data  = alu_res_i;
    end
  end

  // Pipeline registers with synchronous reset discarding in-flight work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '{valid: 1'b0, opc: ALU_OP_ADD, rd: '0, a: '0, b: '0};
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      wb_q <= wb_d;
    end
  end

  assign alu_a_o    = ex_q.a;
  assign alu_b_o    = ex_q.b;
  assign alu_opc_o  = ex_q.opc;
  assign wb_valid_o = wb_q.valid;
  assign wb_rd_o    = wb_q.rd;
  assign wb_data_o  = wb_q.data;

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and writeback stage wrapped around the core's combinational `alu`. Accepts decoded ALU instructions through a valid/ready handshake and reads operands from an internal 2-read/1-write register file. Forwards in-flight results so dependent instructions issue back-to-back, presents operands to the ALU from an EX register, and captures the ALU result into a WB register that commits to the register file.

## Interface
Parameters:
- `WORD_LEN`, 64: datapath width; must match the `alu` instance.
- `NREGS`, 16: architectural registers, power of two; `REG_BITS = $clog2(NREGS)`.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  decoded instruction present.
- `in_ready_o`  out  1  stage can accept; transfer on `in_valid_i & in_ready_o`.
- `in_opc_i`  in  `alu_op_t`  operation.
- `in_rd_i`, `in_rs1_i`, `in_rs2_i`  in  `REG_BITS`  destination and source registers.
- `in_imm_i`  in  `WORD_LEN`  immediate, already extended by the decoder.
- `in_use_imm_i`  in  1  operand B = `in_imm_i` instead of `rs2`.
- `stall_i`  in  1  freeze the whole stage.
- `alu_a_o`, `alu_b_o`  out  `WORD_LEN`  operands to the ALU.
- `alu_opc_o`  out  `alu_op_t`  operation to the ALU.
- `alu_res_i`  in  `WORD_LEN`  ALU result, combinational from `alu_*_o`.
- `wb_valid_o`  out  1  WB register holds a result.
- `wb_rd_o`  out  `REG_BITS`  WB destination register.
- `wb_data_o`  out  `WORD_LEN`  WB result.
- `dbg_addr_i`  in  `REG_BITS`  debug read address.
- `dbg_data_o`  out  `WORD_LEN`  register-file contents at `dbg_addr_i`; combinational, no bypass.

## Operation
- **Pipeline:**
  - ISS: handshake and operand read.
  - EX: registered `ex_valid`, `opc`, `rd`, `a`, `b`, driving `alu_*_o`.
  - WB: registered `wb_valid`, `rd`, `data`.
- **Ready:** `in_ready_o = !stall_i`. With no stall there are no internal hazard stalls, so throughput is 1 instruction per cycle.
- **Operand source priority** for each of `rs1` and `rs2`, evaluated in the accepting cycle:
  1. Register index 0 reads as 0.
  2. If `ex_valid && ex_rd == rs`, use `alu_res_i` (EX forward).
  3. Else if `wb_valid && wb_rd == rs`, use `wb_data` (WB forward).
  4. Else use the register file.
- **Operand B:** `in_imm_i` when `in_use_imm_i`; `rs2` is then ignored.
- **Advance** when `!stall_i`:
  - EX loads the accepted instruction, or a bubble (`ex_valid = 0`) if there is no transfer.
  - WB loads `{ex_valid, ex_rd, alu_res_i}`.
- **Commit:**
  - Condition: `wb_valid && !stall_i && wb_rd != 0`. When it holds, the register file writes `wb_data` at the clock edge.
  - A result targeting register 0 still appears on `wb_*_o` but is never written.
- **Stall:**
  - EX, WB and the register file all hold.
  - `wb_valid_o` stays high across the stall, but the result commits exactly once, on release.
  - `alu_*_o` remain stable.
- **Arithmetic:** results wrap modulo 2^`WORD_LEN`; no flags.
- **Reset:**
  - `ex_valid`, `wb_valid`, `wb_rd_o`, `wb_data_o` and all registers go to 0.
  - `alu_a_o`, `alu_b_o` go to 0; `alu_opc_o` goes to `ALU_OP_ADD`.
  - In-flight instructions are discarded.
  - `in_ready_o` follows `!stall_i` even during reset, but transfers in a reset cycle are dropped.

## Timing
- Accept at cycle N → operands on `alu_*_o` in N+1 → `wb_valid_o` in N+2.
- Register file updated at the end of N+2; `dbg_data_o` reflects the result from N+3.
- Dependent instruction accepted at N+1 gets the value via the EX forward; accepted at N+2, via the WB forward. No bubbles in either case.
- A stall of k cycles delays every stage by exactly k.

## Structure
- `alu_op_t` remains in the shared `alu.svh`.
- Add to the same header:
  - `ex_slot_t`, a packed struct of valid, opc, rd, a, b.
  - `wb_slot_t`, a packed struct of valid, rd, data.
- Sub-module `regfile`: 2 asynchronous read ports, 1 synchronous write port, synchronous reset to zero, `NREGS` × `WORD_LEN`.
- The `alu` instance lives in the parent that connects `alu_*_o` / `alu_res_i`.

## Test plan
- **Reset:** hold `rst_i` 2 cycles mid-stream with 2 ops in flight → `wb_valid_o=0`, all `dbg_data_o` reads 0, no commit of the dropped ops.
- **Immediate chain:** r1=ADD r0,#5; r2=ADD r1,#3; r3=SUB r2,r1 back-to-back → `wb_data_o` 5, 8, 3 in consecutive cycles; no bubble; `dbg` r3=3.
- **WB-forward path:** r4=OR r0,#0xF0, bubble, r5=AND r4,#0x3C → r5=0x30.
- **Register 0 and priority:**
  - rd=0 with ADD r0,#7 → `wb_data_o`=7, r0 still reads 0.
  - Same-rd ops in EX and WB → the EX value is used.
- **Stall:** assert `stall_i` 3 cycles while `wb_valid_o`=1 → `in_ready_o`=0, `wb_*_o` stable, single commit after release.
- **Wrap-around:** r6=SUB r0,#1 → 0xFFFF_FFFF_FFFF_FFFF; ADD r6,#1 → 0.
